// File: rtl/pipelined_decode_ctrl_if.sv
// ID-stage instruction fields in, ID/EX control bundle and hazard status out.
// The master side is the IF/ID register; the slave side is the decode/control block.
interface pipelined_decode_ctrl_if #(
  parameter int ALU_OP_W = 3,
  parameter int REG_AW   = 5
);
  logic                id_valid;
  logic [5:0]          id_op;
  logic [5:0]          id_func;
  logic [REG_AW-1:0]   id_rs;
  logic [REG_AW-1:0]   id_rt;
  logic                flush;

  logic                stall;
  logic                ex_imm_sel;
  logic                ex_mem_write_en;
  logic                ex_mem_read_en;
  logic [1:0]          ex_reg_dest_sel;
  logic [1:0]          ex_reg_data_sel;
  logic                ex_reg_write_en;
  logic [ALU_OP_W-1:0] ex_alu_op;
  logic [REG_AW-1:0]   ex_rt;
  logic                mul_busy;
  logic                illegal_inst;

  modport master (
    output id_valid, id_op, id_func, id_rs, id_rt, flush,
    input  stall, ex_imm_sel, ex_mem_write_en, ex_mem_read_en, ex_reg_dest_sel,
           ex_reg_data_sel, ex_reg_write_en, ex_alu_op, ex_rt, mul_busy, illegal_inst
  );

  modport slave (
    input  id_valid, id_op, id_func, id_rs, id_rt, flush,
    output stall, ex_imm_sel, ex_mem_write_en, ex_mem_read_en, ex_reg_dest_sel,
           ex_reg_data_sel, ex_reg_write_en, ex_alu_op, ex_rt, mul_busy, illegal_inst
  );
endinterface

// File: rtl/pipelined_decode_ctrl.sv
// MIPS ID-stage decode into the ID/EX control register, with load-use bubbles,
// flush, a multi-cycle MULT occupancy counter and illegal-instruction flagging.
module pipelined_decode_ctrl #(
  parameter int ALU_OP_W = 3,
  parameter int MUL_LAT  = 4,
  parameter int REG_AW   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipelined_decode_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_JR    = 6'd8;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;

  localparam logic [ALU_OP_W-1:0] ALU_NOP = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_MUL = ALU_OP_W'(6);

  localparam logic [1:0] DEST_RT  = 2'd0;
  localparam logic [1:0] DEST_RD  = 2'd1;
  localparam logic [1:0] DEST_RA  = 2'd2;
  localparam logic [1:0] DATA_PC4 = 2'd0;
  localparam logic [1:0] DATA_ALU = 2'd1;
  localparam logic [1:0] DATA_MEM = 2'd2;

  typedef struct packed {
    logic                imm_sel;
    logic                mem_write_en;
    logic                mem_read_en;
    logic [1:0]          reg_dest_sel;
    logic [1:0]          reg_data_sel;
    logic                reg_write_en;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  function automatic ctrl_t r_type(input logic [ALU_OP_W-1:0] alu);
    ctrl_t c;
    c              = '0;
    c.reg_dest_sel = DEST_RD;
    c.reg_data_sel = DATA_ALU;
    c.reg_write_en = 1'b1;
    c.alu_op       = alu;
    return c;
  endfunction

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mul_busy;
  ctrl_t             r_ctrl;
  logic [REG_AW-1:0] r_ex_rt;
  logic              r_illegal;

  ctrl_t w_dec;
  logic  w_illegal;
  logic  w_uses_rt;
  logic  w_lu_haz;
  logic  w_stall;
  logic  w_bubble;
  logic  w_load;
  logic  w_mul_start;

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    w_dec     = '0;
    w_illegal = 1'b0;
    case (bus.id_op)
      OP_RTYPE: begin
        case (bus.id_func)
          FN_ADD:        w_dec = r_type(ALU_ADD);
          FN_SUB:        w_dec = r_type(ALU_SUB);
          FN_AND:        w_dec = r_type(ALU_AND);
          FN_OR:         w_dec = r_type(ALU_OR);
          FN_SLT:        w_dec = r_type(ALU_SLT);
          FN_MULT:       w_dec = r_type(ALU_MUL);
          FN_SLL, FN_JR: w_dec = '0;
          default:       w_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_SLTI: begin
        w_dec.imm_sel      = 1'b1;
        w_dec.reg_dest_sel = DEST_RT;
        w_dec.reg_data_sel = DATA_ALU;
        w_dec.reg_write_en = 1'b1;
        w_dec.alu_op       = (bus.id_op == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      OP_LW: begin
        w_dec.imm_sel      = 1'b1;
        w_dec.mem_read_en  = 1'b1;
        w_dec.reg_data_sel = DATA_MEM;
        w_dec.reg_write_en = 1'b1;
        w_dec.alu_op       = ALU_ADD;
      end
      OP_SW: begin
        w_dec.imm_sel      = 1'b1;
        w_dec.mem_write_en = 1'b1;
        w_dec.alu_op       = ALU_ADD;
      end
      OP_JAL: begin
        w_dec.reg_dest_sel = DEST_RA;
        w_dec.reg_data_sel = DATA_PC4;
        w_dec.reg_write_en = 1'b1;
        w_dec.alu_op       = ALU_NOP;
      end
      OP_BEQ, OP_J: w_dec = '0;
      default:      w_illegal = 1'b1;
    endcase
  end

  assign w_uses_rt = (bus.id_op == OP_RTYPE) || (bus.id_op == OP_BEQ) || (bus.id_op == OP_SW);

  // A load in EX whose destination feeds the ID instruction needs one bubble;
  // $0 is never a real dependency.
  assign w_lu_haz = bus.id_valid && r_ctrl.mem_read_en && (r_ex_rt != '0) &&
                    ((r_ex_rt == bus.id_rs) || (w_uses_rt && (r_ex_rt == bus.id_rt)));

  assign w_stall     = r_mul_busy || w_lu_haz;
  assign w_bubble    = !r_mul_busy && (bus.flush || w_lu_haz || !bus.id_valid);
  assign w_load      = !r_mul_busy && !w_bubble;
  assign w_mul_start = w_load && (w_dec.alu_op == ALU_MUL) && (MUL_LAT > 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_mul_busy <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
      case (r_state)
        S_IDLE: begin
          if (w_mul_start) begin
            r_state    <= S_MUL;
            r_cnt      <= CNT_W'(MUL_LAT - 1);
            r_mul_busy <= 1'b1;
          end
        end
        S_MUL: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_mul_busy <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_cnt      <= '0;
          r_mul_busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl    <= '0;
      r_ex_rt   <= '0;
      r_illegal <= 1'b0;
    end else begin
      // Flag only when the instruction leaves ID, so a stalled one pulses once.
      r_illegal <= bus.id_valid && !bus.flush && !w_stall && w_illegal;
      if (w_bubble) begin
        r_ctrl  <= '0;
        r_ex_rt <= '0;
      end else if (w_load) begin
        r_ctrl  <= w_dec;
        r_ex_rt <= bus.id_rt;
      end
    end
  end

  assign bus.stall           = w_stall;
  assign bus.ex_imm_sel      = r_ctrl.imm_sel;
  assign bus.ex_mem_write_en = r_ctrl.mem_write_en;
  assign bus.ex_mem_read_en  = r_ctrl.mem_read_en;
  assign bus.ex_reg_dest_sel = r_ctrl.reg_dest_sel;
  assign bus.ex_reg_data_sel = r_ctrl.reg_data_sel;
  assign bus.ex_reg_write_en = r_ctrl.reg_write_en;
  assign bus.ex_alu_op       = r_ctrl.alu_op;
  assign bus.ex_rt           = r_ex_rt;
  assign bus.mul_busy        = r_mul_busy;
  assign bus.illegal_inst    = r_illegal;

endmodule

// File: tb/tb_pipelined_decode_ctrl.sv
// Bench for pipelined_decode_ctrl: decode table, hand-written hazard/MULT/flush/reset
// sequences, and random traffic against a remaining-cycles reference model (MUL_LAT 4 and 1).
module tb_pipelined_decode_ctrl;

  typedef struct packed {
    logic       imm;
    logic       mw;
    logic       mr;
    logic [1:0] dest;
    logic [1:0] data;
    logic       we;
    logic [2:0] alu;
    logic [4:0] rt;
    logic       busy;
    logic       ill;
  } outs_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    outs_t      exp;
  } vec_t;

  logic clk;
  logic rst_n;
  logic       id_valid;
  logic [5:0] id_op;
  logic [5:0] id_func;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       flush;

  int n_vec;
  int n_miss;

  outs_t m [2];
  int    rem [2];
  int    lat [2];

  pipelined_decode_ctrl_if #(.ALU_OP_W(3), .REG_AW(5)) bus_a ();
  pipelined_decode_ctrl_if #(.ALU_OP_W(3), .REG_AW(5)) bus_b ();

  assign bus_a.id_valid = id_valid;
  assign bus_a.id_op    = id_op;
  assign bus_a.id_func  = id_func;
  assign bus_a.id_rs    = id_rs;
  assign bus_a.id_rt    = id_rt;
  assign bus_a.flush    = flush;
  assign bus_b.id_valid = id_valid;
  assign bus_b.id_op    = id_op;
  assign bus_b.id_func  = id_func;
  assign bus_b.id_rs    = id_rs;
  assign bus_b.id_rt    = id_rt;
  assign bus_b.flush    = flush;

  pipelined_decode_ctrl #(.ALU_OP_W(3), .MUL_LAT(4), .REG_AW(5)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  pipelined_decode_ctrl #(.ALU_OP_W(3), .MUL_LAT(1), .REG_AW(5)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t mk(input logic imm, mw, mr, input logic [1:0] dest, data,
                               input logic we, input logic [2:0] alu, input logic [4:0] rt,
                               input logic busy, ill);
    outs_t o;
    o = {imm, mw, mr, dest, data, we, alu, rt, busy, ill};
    return o;
  endfunction

  function automatic outs_t dut_outs(input int k);
    outs_t o;
    if (k == 0)
      o = {bus_a.ex_imm_sel, bus_a.ex_mem_write_en, bus_a.ex_mem_read_en, bus_a.ex_reg_dest_sel,
           bus_a.ex_reg_data_sel, bus_a.ex_reg_write_en, bus_a.ex_alu_op, bus_a.ex_rt,
           bus_a.mul_busy, bus_a.illegal_inst};
    else
      o = {bus_b.ex_imm_sel, bus_b.ex_mem_write_en, bus_b.ex_mem_read_en, bus_b.ex_reg_dest_sel,
           bus_b.ex_reg_data_sel, bus_b.ex_reg_write_en, bus_b.ex_alu_op, bus_b.ex_rt,
           bus_b.mul_busy, bus_b.illegal_inst};
    return o;
  endfunction

  // Instruction meaning straight from the decode table; rt/busy left 0, ill marks illegal.
  function automatic outs_t ref_decode(input logic [5:0] op, input logic [5:0] fn);
    outs_t d;
    d = '0;
    case (op)
      6'd0: begin
        case (fn)
          6'd32:      d = mk(0, 0, 0, 2'd1, 2'd1, 1, 3'd1, 5'd0, 0, 0);
          6'd34:      d = mk(0, 0, 0, 2'd1, 2'd1, 1, 3'd2, 5'd0, 0, 0);
          6'd36:      d = mk(0, 0, 0, 2'd1, 2'd1, 1, 3'd3, 5'd0, 0, 0);
          6'd37:      d = mk(0, 0, 0, 2'd1, 2'd1, 1, 3'd4, 5'd0, 0, 0);
          6'd42:      d = mk(0, 0, 0, 2'd1, 2'd1, 1, 3'd5, 5'd0, 0, 0);
          6'd24:      d = mk(0, 0, 0, 2'd1, 2'd1, 1, 3'd6, 5'd0, 0, 0);
          6'd0, 6'd8: d = '0;
          default:    d.ill = 1'b1;
        endcase
      end
      6'd8:       d = mk(1, 0, 0, 2'd0, 2'd1, 1, 3'd1, 5'd0, 0, 0);
      6'd10:      d = mk(1, 0, 0, 2'd0, 2'd1, 1, 3'd5, 5'd0, 0, 0);
      6'd35:      d = mk(1, 0, 1, 2'd0, 2'd2, 1, 3'd1, 5'd0, 0, 0);
      6'd43:      d = mk(1, 1, 0, 2'd0, 2'd0, 0, 3'd1, 5'd0, 0, 0);
      6'd3:       d = mk(0, 0, 0, 2'd2, 2'd0, 1, 3'd0, 5'd0, 0, 0);
      6'd4, 6'd2: d = '0;
      default:    d.ill = 1'b1;
    endcase
    return d;
  endfunction

  function automatic bit model_lu(input int k);
    bit uses_rt;
    uses_rt = (id_op == 6'd0) || (id_op == 6'd4) || (id_op == 6'd43);
    return id_valid && m[k].mr && (m[k].rt != 5'd0) &&
           ((m[k].rt == id_rs) || (uses_rt && (m[k].rt == id_rt)));
  endfunction

  function automatic logic model_stall(input int k);
    return (rem[k] > 0) || model_lu(k);
  endfunction

  // EX occupancy modelled as a count of extra cycles the MULT still needs.
  task automatic model_step(input int k);
    outs_t d;
    bit    lu;
    bit    ill;
    if (rem[k] > 0) begin
      rem[k]    = rem[k] - 1;
      m[k].ill  = 1'b0;
      m[k].busy = (rem[k] > 0);
    end else begin
      lu  = model_lu(k);
      d   = ref_decode(id_op, id_func);
      ill = id_valid && !flush && !lu && d.ill;
      if (flush || lu || !id_valid) begin
        m[k] = '0;
      end else begin
        m[k]    = d;
        m[k].rt = id_rt;
        if (d.alu == 3'd6 && lat[k] > 1) rem[k] = lat[k] - 1;
      end
      m[k].ill  = ill;
      m[k].busy = (rem[k] > 0);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m[k]   = '0;
      rem[k] = 0;
    end
  endtask

  task automatic check(input string name, input outs_t act, input outs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic fl);
    id_valid = v;
    id_op    = op;
    id_func  = fn;
    id_rs    = rs;
    id_rt    = rt;
    flush    = fl;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // Advance one clock; returns at the following falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
  endtask

  vec_t  vecs [16];
  logic [5:0] rop [18];
  logic [5:0] rfn [18];

  initial begin
    n_vec  = 0;
    n_miss = 0;
    lat[0] = 4;
    lat[1] = 1;
    model_reset();
    rst_n = 1'b0;
    drive(1'b1, 6'd0, 6'd32, 5'd1, 5'd2, 1'b0);

    vecs[0]  = '{"add",   6'd0,  6'd32, mk(0, 0, 0, 2'd1, 2'd1, 1, 3'd1, 5'd2, 0, 0)};
    vecs[1]  = '{"sub",   6'd0,  6'd34, mk(0, 0, 0, 2'd1, 2'd1, 1, 3'd2, 5'd2, 0, 0)};
    vecs[2]  = '{"and",   6'd0,  6'd36, mk(0, 0, 0, 2'd1, 2'd1, 1, 3'd3, 5'd2, 0, 0)};
    vecs[3]  = '{"or",    6'd0,  6'd37, mk(0, 0, 0, 2'd1, 2'd1, 1, 3'd4, 5'd2, 0, 0)};
    vecs[4]  = '{"slt",   6'd0,  6'd42, mk(0, 0, 0, 2'd1, 2'd1, 1, 3'd5, 5'd2, 0, 0)};
    vecs[5]  = '{"mult",  6'd0,  6'd24, mk(0, 0, 0, 2'd1, 2'd1, 1, 3'd6, 5'd2, 1, 0)};
    vecs[6]  = '{"sll0",  6'd0,  6'd0,  mk(0, 0, 0, 2'd0, 2'd0, 0, 3'd0, 5'd2, 0, 0)};
    vecs[7]  = '{"jr",    6'd0,  6'd8,  mk(0, 0, 0, 2'd0, 2'd0, 0, 3'd0, 5'd2, 0, 0)};
    vecs[8]  = '{"addi",  6'd8,  6'd32, mk(1, 0, 0, 2'd0, 2'd1, 1, 3'd1, 5'd2, 0, 0)};
    vecs[9]  = '{"slti",  6'd10, 6'd32, mk(1, 0, 0, 2'd0, 2'd1, 1, 3'd5, 5'd2, 0, 0)};
    vecs[10] = '{"lw",    6'd35, 6'd32, mk(1, 0, 1, 2'd0, 2'd2, 1, 3'd1, 5'd2, 0, 0)};
    vecs[11] = '{"sw",    6'd43, 6'd32, mk(1, 1, 0, 2'd0, 2'd0, 0, 3'd1, 5'd2, 0, 0)};
    vecs[12] = '{"beq",   6'd4,  6'd32, mk(0, 0, 0, 2'd0, 2'd0, 0, 3'd0, 5'd2, 0, 0)};
    vecs[13] = '{"j",     6'd2,  6'd32, mk(0, 0, 0, 2'd0, 2'd0, 0, 3'd0, 5'd2, 0, 0)};
    vecs[14] = '{"jal",   6'd3,  6'd32, mk(0, 0, 0, 2'd2, 2'd0, 1, 3'd0, 5'd2, 0, 0)};
    vecs[15] = '{"badfn", 6'd0,  6'd63, mk(0, 0, 0, 2'd0, 2'd0, 0, 3'd0, 5'd2, 0, 1)};

    rop = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd8, 6'd10,
            6'd35, 6'd35, 6'd43, 6'd4, 6'd2, 6'd3, 6'd63, 6'd0};
    rfn = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd24, 6'd0, 6'd8, 6'd0, 6'd0,
            6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd63};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_a", dut_outs(0), '0);
    check("reset_b", dut_outs(1), '0);
    check_bit("reset_stall", bus_a.stall, 1'b0);
    rst_n = 1'b1;

    // add $3,$1,$2
    drive(1'b1, 6'd0, 6'd32, 5'd1, 5'd2, 1'b0);
    #1 check_bit("add_stall", bus_a.stall, 1'b0);
    tick();
    check("add_ex", dut_outs(0), mk(0, 0, 0, 2'd1, 2'd1, 1, 3'd1, 5'd2, 0, 0));

    // lw $5,0($1) then add $6,$5,$2: one bubble
    drive(1'b1, 6'd35, 6'd0, 5'd1, 5'd5, 1'b0);
    tick();
    check("lw_ex", dut_outs(0), mk(1, 0, 1, 2'd0, 2'd2, 1, 3'd1, 5'd5, 0, 0));
    drive(1'b1, 6'd0, 6'd32, 5'd5, 5'd2, 1'b0);
    #1 check_bit("lu_stall", bus_a.stall, 1'b1);
    tick();
    check("lu_bubble", dut_outs(0), '0);
    #1 check_bit("lu_stall_clear", bus_a.stall, 1'b0);
    tick();
    check("lu_add_issue", dut_outs(0), mk(0, 0, 0, 2'd1, 2'd1, 1, 3'd1, 5'd2, 0, 0));

    // lw $0 then use of $0: no hazard
    drive(1'b1, 6'd35, 6'd0, 5'd1, 5'd0, 1'b0);
    tick();
    drive(1'b1, 6'd0, 6'd32, 5'd0, 5'd0, 1'b0);
    #1 check_bit("lw0_stall", bus_a.stall, 1'b0);
    tick();
    check("lw0_add", dut_outs(0), mk(0, 0, 0, 2'd1, 2'd1, 1, 3'd1, 5'd0, 0, 0));

    // MULT then add: MUL_LAT=4 stalls 3 cycles, MUL_LAT=1 none
    drive(1'b1, 6'd0, 6'd24, 5'd1, 5'd2, 1'b0);
    tick();
    check("mul_enter_a", dut_outs(0), mk(0, 0, 0, 2'd1, 2'd1, 1, 3'd6, 5'd2, 1, 0));
    check("mul_enter_b", dut_outs(1), mk(0, 0, 0, 2'd1, 2'd1, 1, 3'd6, 5'd2, 0, 0));
    drive(1'b1, 6'd0, 6'd32, 5'd3, 5'd4, 1'b0);
    #1 check_bit("mul1_stall_b", bus_b.stall, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      #1 check_bit($sformatf("mul_stall_%0d", i), bus_a.stall, 1'b1);
      tick();
      check($sformatf("mul_hold_%0d", i), dut_outs(0),
            mk(0, 0, 0, 2'd1, 2'd1, 1, 3'd6, 5'd2, (i < 3), 0));
      if (i == 1)
        check("mul1_add_b", dut_outs(1), mk(0, 0, 0, 2'd1, 2'd1, 1, 3'd1, 5'd4, 0, 0));
    end
    #1 check_bit("mul_stall_end", bus_a.stall, 1'b0);
    tick();
    check("mul_add_issue", dut_outs(0), mk(0, 0, 0, 2'd1, 2'd1, 1, 3'd1, 5'd4, 0, 0));

    // flush with sw in ID
    drive(1'b1, 6'd43, 6'd0, 5'd1, 5'd2, 1'b1);
    tick();
    check("flush_sw", dut_outs(0), '0);

    // flush during mul_busy is ignored
    drive(1'b1, 6'd0, 6'd24, 5'd1, 5'd2, 1'b0);
    tick();
    drive(1'b1, 6'd0, 6'd32, 5'd3, 5'd4, 1'b1);
    tick();
    check("flush_in_mul", dut_outs(0), mk(0, 0, 0, 2'd1, 2'd1, 1, 3'd6, 5'd2, 1, 0));
    idle();
    repeat (3) tick();

    // illegal opcode: one-cycle pulse
    drive(1'b1, 6'd63, 6'd0, 5'd1, 5'd2, 1'b0);
    tick();
    check("illegal_pulse", dut_outs(0), mk(0, 0, 0, 2'd0, 2'd0, 0, 3'd0, 5'd2, 0, 1));
    idle();
    tick();
    check("illegal_clear", dut_outs(0), '0);

    // reset asserted mid-MUL clears asynchronously
    drive(1'b1, 6'd0, 6'd24, 5'd1, 5'd2, 1'b0);
    tick();
    idle();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_mul_a", dut_outs(0), '0);
    check("rst_mid_mul_b", dut_outs(1), '0);
    check_bit("rst_mid_mul_stall", bus_a.stall, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // decode table
    for (int v = 0; v < 16; v++) begin
      drive(1'b1, vecs[v].op, vecs[v].fn, 5'd1, 5'd2, 1'b0);
      tick();
      check(vecs[v].name, dut_outs(0), vecs[v].exp);
      idle();
      repeat (4) tick();
    end

    // random traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      int sel;
      sel = $urandom_range(0, 17);
      drive(($urandom_range(0, 9) != 0), rop[sel], rfn[sel],
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
      #1;
      check_bit($sformatf("rand_stall_a_%0d", c), bus_a.stall, model_stall(0));
      check_bit($sformatf("rand_stall_b_%0d", c), bus_b.stall, model_stall(1));
      tick();
      check($sformatf("rand_a_%0d", c), dut_outs(0), m[0]);
      check($sformatf("rand_b_%0d", c), dut_outs(1), m[1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
